// File: rtl/xor_pkg.sv
// -----------------------------------------------------------------------------
// xor_pkg
//   Shared definitions for the xor_4bits datapath family.
//   - DATA_W      : width of the XOR datapath words and of the checksum
//   - chk_state_t : control states of the framed checksum unit
// -----------------------------------------------------------------------------
package xor_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } chk_state_t;

endpackage : xor_pkg

// File: rtl/xor_checksum_4bits.sv
// -----------------------------------------------------------------------------
// xor_checksum_4bits
//   Folds a frame of FRAME_LEN words into a running XOR checksum using a
//   valid/ready input handshake, then presents the checksum with a held
//   valid/ready output handshake until the consumer takes it.
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-high reset
//   start_i      in   begin a new frame (only honoured in IDLE)
//   valid_i      in   data_i carries a word
//   data_i       in   word folded into the checksum
//   ready_o      out  a word is accepted this cycle when valid_i is high
//   sum_o        out  frame checksum, stable while sum_valid_o is high
//   sum_valid_o  out  checksum available
//   sum_ready_i  in   consumer takes the checksum
//   busy_o       out  frame in progress (ACCUM or DONE)
//   count_o      out  words accepted in the current frame
//
// Every output comes straight from a flop, so no input reaches an output
// combinationally. The status flops are loaded from the next-state value,
// which keeps them exactly aligned with the state register.
// -----------------------------------------------------------------------------
module xor_checksum_4bits
    import xor_pkg::*;
#(
    parameter  int DATA_W    = xor_pkg::DATA_W,
    parameter  int FRAME_LEN = 8,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] sum_o,
    output logic              sum_valid_o,
    input  logic              sum_ready_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  count_o
);

    // Count value held before the accept that completes the frame.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    chk_state_t          state_q,     state_d;
    logic [DATA_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [DATA_W-1:0]   sum_q,       sum_d;
    logic                ready_q,     ready_d;
    logic                sum_valid_q, sum_valid_d;
    logic                busy_q,      busy_d;
    logic [DATA_W-1:0]   acc_next_s;

    // Checksum value after folding in the word currently on data_i.
    always_comb begin
        acc_next_s = acc_q ^ data_i;
    end

    // Next-state, accumulator, counter and checksum update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;

        case (state_q)
            IDLE: begin
                // valid_i is deliberately ignored here, even alongside start_i.
                if (start_i) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            ACCUM: begin
                // ready is high for the whole of ACCUM, so valid_i alone
                // qualifies an accept.
                if (valid_i) begin
                    acc_d = acc_next_s;
                    cnt_d = cnt_q + ONE_CNT;
                    if (cnt_q == LAST_CNT) begin
                        sum_d   = acc_next_s;
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end

            DONE: begin
                // count stays at FRAME_LEN until the checksum is taken;
                // sum keeps its value past DONE.
                if (sum_ready_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Status outputs decoded from the next state so they register in step
    // with the state flop.
    always_comb begin
        ready_d     = 1'b0;
        sum_valid_d = 1'b0;
        busy_d      = 1'b0;

        case (state_d)
            IDLE: begin
                ready_d     = 1'b0;
                sum_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
            ACCUM: begin
                ready_d     = 1'b1;
                sum_valid_d = 1'b0;
                busy_d      = 1'b1;
            end
            DONE: begin
                ready_d     = 1'b0;
                sum_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: begin
                ready_d     = 1'b0;
                sum_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            ready_q     <= 1'b0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            ready_q     <= ready_d;
            sum_valid_q <= sum_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign ready_o     = ready_q;
    assign sum_o       = sum_q;
    assign sum_valid_o = sum_valid_q;
    assign busy_o      = busy_q;
    assign count_o     = cnt_q;

endmodule : xor_checksum_4bits
